wb_port_scheduler: RTL and testbench
====================================

Name: wb_port_scheduler

Overview:
- Sequences the single write port (write_en/A3/WD3) of the 8x16 register file between two writeback requesters: the ALU and the load unit.
- Keeps a per-register pending scoreboard, set at issue and cleared at writeback commit.
- Provides RAW-hazard stall information to the decode stage.
- Sits between execute/memory stages and the register file in the multi-cycle and pipelined cores.

Parameters:
DATA_W, 16, register/write data width
ADDR_W, 3, register address width; NREG = 2**ADDR_W (8)
CNT_W, 16, width of committed-write counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous, active-low reset
iss_valid  in  1  decode issues an instruction with a destination this cycle
iss_rd  in  ADDR_W  destination of issued instruction
q_rs1  in  ADDR_W  source 1 to check
q_rs2  in  ADDR_W  source 2 to check
hazard  out  1  pending[q_rs1] | pending[q_rs2] (combinational)
alu_valid  in  1  ALU writeback request
alu_rd  in  ADDR_W  ALU destination
alu_data  in  DATA_W  ALU result
alu_ready  out  1  ALU request accepted this cycle
ld_valid  in  1  load writeback request
ld_rd  in  ADDR_W  load destination
ld_data  in  DATA_W  load data
ld_ready  out  1  load request accepted this cycle
rf_write_en  out  1  to register file write_en
rf_A3  out  ADDR_W  to register file A3
rf_WD3  out  DATA_W  to register file WD3
pending  out  NREG  scoreboard bitmap, bit i = register i awaiting writeback
wb_count  out  CNT_W  committed (non-R0) writes, wraps modulo 2**CNT_W
err_unexpected  out  1  sticky: write committed to a register not pending

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately even mid-transfer):
  - pending=0, rf_write_en=0, rf_A3=0, rf_WD3=0, wb_count=0, err_unexpected=0.
  - last_grant=LD, so the ALU wins the first tie.
  - An in-flight registered write is discarded.
- Arbitration (combinational; one grant per cycle):
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not granted last time is granted (round-robin).
  - last_grant updates only on a cycle with a grant.
  - alu_ready/ld_ready = that requester's grant. Transfer occurs when valid & ready.
  - A valid must be held stable until ready.
  - No requester is ever blocked two consecutive cycles.
- Write stage (registered; latency 1):
  - Grant in cycle N → rf_write_en=1, rf_A3=rd, rf_WD3=data during cycle N+1.
  - The register file captures the write at the end of N+1.
  - No grant in cycle N → rf_write_en=0 in N+1; rf_A3/rf_WD3 hold their previous values.
  - Throughput: one write per cycle, back-to-back.
- R0:
  - A granted request with rd=0 is accepted (ready=1).
  - It produces rf_write_en=0, is not counted, and does not touch pending or err_unexpected.
- Scoreboard (all updates on the rising edge):
  - Clear pending[rf_A3] at the end of a cycle with rf_write_en=1, i.e. same edge as the register-file write.
  - Set pending[iss_rd] when iss_valid and iss_rd≠0; iss_rd=0 is ignored.
  - Same register set and cleared on the same edge: set wins (the new producer is outstanding).
  - pending[0] is always 0.
- hazard:
  - Combinational from the current pending bits.
  - Goes low the cycle after the commit edge, when register-file reads already return the new data.
  - q_rs=0 never contributes.
- wb_count: increments by 1 per cycle with rf_write_en=1; wraps 0xFFFF→0x0000.
- err_unexpected:
  - Set when rf_write_en=1 and pending[rf_A3]=0 at that edge.
  - Stays 1 until reset. Data is still written.

Test Plan:
- Reset, then iss rd=5; q_rs1=5 → hazard=1, pending=0x20. Next, alu_valid rd=5 data=0x1234 → alu_ready=1; next cycle rf_write_en=1, A3=5, WD3=0x1234; after that edge pending=0x00, hazard=0, wb_count=1.
- Issue rd=1..4; hold alu_valid(rd=1,2) and ld_valid(rd=3,4) continuously → grants ALU,LD,ALU,LD; four consecutive rf_write_en cycles; wb_count=4; pending=0.
- ld_valid rd=0 data=0xBEEF → ld_ready=1; rf_write_en stays 0; wb_count unchanged; err_unexpected=0.
- pending[3]=1, commit write to rd=3 while iss_valid rd=3 on the same edge → pending[3] remains 1, hazard on rs2=3 stays 1.
- alu write to rd=6 with pending[6]=0 → rf_write_en=1 next cycle, err_unexpected=1 and stays 1 after further legal writes.
- Reset mid-stream: rst_n low during a cycle with rf_write_en=1 and pending=0xFE → all outputs 0 immediately (before the next clk edge); first post-reset tie grants ALU.

Source files
------------

// File: rtl/wb_port_scheduler.sv
// Writeback port scheduler: round-robin arbitration of ALU and load writebacks onto
// the single register-file write port, plus a per-register pending scoreboard.
module wb_port_scheduler #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   iss_valid,
    input  logic [ADDR_W-1:0]      iss_rd,
    input  logic [ADDR_W-1:0]      q_rs1,
    input  logic [ADDR_W-1:0]      q_rs2,
    output logic                   hazard,
    input  logic                   alu_valid,
    input  logic [ADDR_W-1:0]      alu_rd,
    input  logic [DATA_W-1:0]      alu_data,
    output logic                   alu_ready,
    input  logic                   ld_valid,
    input  logic [ADDR_W-1:0]      ld_rd,
    input  logic [DATA_W-1:0]      ld_data,
    output logic                   ld_ready,
    output logic                   rf_write_en,
    output logic [ADDR_W-1:0]      rf_A3,
    output logic [DATA_W-1:0]      rf_WD3,
    output logic [2**ADDR_W-1:0]   pending,
    output logic [CNT_W-1:0]       wb_count,
    output logic                   err_unexpected
);

    localparam int NREG = 2**ADDR_W;

    typedef enum logic {
        GR_ALU = 1'b0,
        GR_LD  = 1'b1
    } grant_e;

    grant_e              last_grant_q, last_grant_d;
    logic                grant_alu_s;
    logic                grant_ld_s;
    logic                grant_any_s;
    logic [ADDR_W-1:0]   grant_rd_s;
    logic [DATA_W-1:0]   grant_data_s;

    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   a3_q, a3_d;
    logic [DATA_W-1:0]   wd3_q, wd3_d;
    logic [NREG-1:0]     pending_q, pending_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;

    function automatic logic [NREG-1:0] onehot(input logic [ADDR_W-1:0] addr);
        onehot = {{(NREG-1){1'b0}}, 1'b1} << addr;
    endfunction

    // Arbitration: single requester wins outright; a tie goes to whoever lost last time.
    always_comb begin
        grant_alu_s = 1'b0;
        grant_ld_s  = 1'b0;
        if (alu_valid && ld_valid) begin
            if (last_grant_q == GR_LD) begin
                grant_alu_s = 1'b1;
            end else begin
                grant_ld_s = 1'b1;
            end
        end else begin
            grant_alu_s = alu_valid;
            grant_ld_s  = ld_valid;
        end
        grant_any_s = grant_alu_s | grant_ld_s;
        if (grant_ld_s) begin
            grant_rd_s   = ld_rd;
            grant_data_s = ld_data;
        end else begin
            grant_rd_s   = alu_rd;
            grant_data_s = alu_data;
        end
        if (grant_any_s) begin
            last_grant_d = grant_ld_s ? GR_LD : GR_ALU;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Write stage next state: R0 grants are consumed without producing a write.
    always_comb begin
        wr_en_d = grant_any_s && (grant_rd_s != {ADDR_W{1'b0}});
        if (wr_en_d) begin
            a3_d  = grant_rd_s;
            wd3_d = grant_data_s;
        end else begin
            a3_d  = a3_q;
            wd3_d = wd3_q;
        end
    end

    // Scoreboard, commit counter and unexpected-write flag; a same-edge issue beats the clear.
    always_comb begin
        pending_d = pending_q;
        if (wr_en_q) begin
            pending_d = pending_d & ~onehot(a3_q);
        end else begin
            pending_d = pending_q;
        end
        if (iss_valid && (iss_rd != {ADDR_W{1'b0}})) begin
            pending_d = pending_d | onehot(iss_rd);
        end else begin
            pending_d = pending_d;
        end
        pending_d[0] = 1'b0;

        if (wr_en_q) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            err_d = err_q | ~pending_q[a3_q];
        end else begin
            cnt_d = cnt_q;
            err_d = err_q;
        end
    end

    // State registers; reset also discards any write already staged for the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GR_LD;
            wr_en_q      <= 1'b0;
            a3_q         <= {ADDR_W{1'b0}};
            wd3_q        <= {DATA_W{1'b0}};
            pending_q    <= {NREG{1'b0}};
            cnt_q        <= {CNT_W{1'b0}};
            err_q        <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            wr_en_q      <= wr_en_d;
            a3_q         <= a3_d;
            wd3_q        <= wd3_d;
            pending_q    <= pending_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
        end
    end

    assign hazard = ((q_rs1 != {ADDR_W{1'b0}}) & pending_q[q_rs1]) |
                    ((q_rs2 != {ADDR_W{1'b0}}) & pending_q[q_rs2]);

    assign alu_ready      = grant_alu_s;
    assign ld_ready       = grant_ld_s;
    assign rf_write_en    = wr_en_q;
    assign rf_A3          = a3_q;
    assign rf_WD3         = wd3_q;
    assign pending        = pending_q;
    assign wb_count       = cnt_q;
    assign err_unexpected = err_q;

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Bench for wb_port_scheduler: directed scenarios plus randomized traffic, all checked
// against a cycle-level behavioural model of the scheduling rules.
module tb_wb_port_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iss_valid;
    logic [2:0]  iss_rd, q_rs1, q_rs2;
    logic        hazard;
    logic        alu_valid, ld_valid, alu_ready, ld_ready;
    logic [2:0]  alu_rd, ld_rd;
    logic [15:0] alu_data, ld_data;
    logic        rf_write_en;
    logic [2:0]  rf_A3;
    logic [15:0] rf_WD3;
    logic [7:0]  pending;
    logic [15:0] wb_count;
    logic        err_unexpected;

    always #5 clk = ~clk;

    wb_port_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .q_rs1(q_rs1), .q_rs2(q_rs2), .hazard(hazard),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .rf_write_en(rf_write_en), .rf_A3(rf_A3), .rf_WD3(rf_WD3),
        .pending(pending), .wb_count(wb_count), .err_unexpected(err_unexpected)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct { bit [2:0] rd; bit [15:0] data; } req_t;
    req_t alu_q[$];
    req_t ld_q[$];

    // Reference model state
    bit        m_pend [8];
    bit        m_last_was_ld;
    bit        m_wen;
    bit [2:0]  m_a3;
    bit [15:0] m_wd;
    int unsigned m_cnt;
    bit        m_err;
    bit        m_ga, m_gl;

    function automatic void m_reset();
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        m_last_was_ld = 1'b1;
        m_wen = 1'b0;
        m_cnt = 0;
        m_err = 1'b0;
    endfunction

    function automatic logic [7:0] m_pend_vec();
        logic [7:0] v = 8'h00;
        for (int i = 0; i < 8; i++) v[i] = m_pend[i];
        return v;
    endfunction

    // One clock cycle: drive requests from the queues, check mid-cycle, advance the model.
    task automatic step();
        bit exp_haz;
        alu_valid = (alu_q.size() > 0);
        if (alu_valid) begin alu_rd = alu_q[0].rd; alu_data = alu_q[0].data; end
        ld_valid = (ld_q.size() > 0);
        if (ld_valid) begin ld_rd = ld_q[0].rd; ld_data = ld_q[0].data; end
        #3;
        if (alu_valid && ld_valid) begin
            m_ga = m_last_was_ld;
            m_gl = !m_last_was_ld;
        end else begin
            m_ga = alu_valid;
            m_gl = ld_valid;
        end
        exp_haz = (q_rs1 != 3'd0 && m_pend[q_rs1]) || (q_rs2 != 3'd0 && m_pend[q_rs2]);
        chk("alu_ready", {31'd0, alu_ready}, {31'd0, m_ga});
        chk("ld_ready", {31'd0, ld_ready}, {31'd0, m_gl});
        chk("hazard", {31'd0, hazard}, {31'd0, exp_haz});
        chk("pending", {24'd0, pending}, {24'd0, m_pend_vec()});
        chk("rf_write_en", {31'd0, rf_write_en}, {31'd0, m_wen});
        if (m_wen) begin
            chk("rf_A3", {29'd0, rf_A3}, {29'd0, m_a3});
            chk("rf_WD3", {16'd0, rf_WD3}, {16'd0, m_wd});
        end
        chk("wb_count", {16'd0, wb_count}, m_cnt % 32'h10000);
        chk("err_unexpected", {31'd0, err_unexpected}, {31'd0, m_err});

        // Commit of the staged write, then issue (issue wins on the same register)
        if (m_wen) begin
            if (!m_pend[m_a3]) m_err = 1'b1;
            m_pend[m_a3] = 1'b0;
            m_cnt++;
        end
        if (iss_valid && iss_rd != 3'd0) m_pend[iss_rd] = 1'b1;
        if (m_ga || m_gl) m_last_was_ld = m_gl;
        m_wen = 1'b0;
        if (m_ga) begin
            m_wen = (alu_q[0].rd != 3'd0);
            if (m_wen) begin m_a3 = alu_q[0].rd; m_wd = alu_q[0].data; end
            void'(alu_q.pop_front());
        end
        if (m_gl) begin
            m_wen = (ld_q[0].rd != 3'd0);
            if (m_wen) begin m_a3 = ld_q[0].rd; m_wd = ld_q[0].data; end
            void'(ld_q.pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit [2:0] rd);
        iss_valid = 1'b1;
        iss_rd = rd;
        step();
        iss_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        iss_valid = 1'b0; iss_rd = 3'd0; q_rs1 = 3'd0; q_rs2 = 3'd0;
        alu_valid = 1'b0; alu_rd = 3'd0; alu_data = 16'h0000;
        ld_valid = 1'b0; ld_rd = 3'd0; ld_data = 16'h0000;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_pending", {24'd0, pending}, 32'h0);
        chk("rst_wen", {31'd0, rf_write_en}, 32'h0);
        chk("rst_count", {16'd0, wb_count}, 32'h0);

        // Issue then ALU writeback of r5
        q_rs1 = 3'd5;
        issue(3'd5);
        chk("t1_pending", {24'd0, pending}, 32'h20);
        chk("t1_hazard", {31'd0, hazard}, 32'h1);
        alu_q.push_back('{3'd5, 16'h1234});
        step();
        chk("t1_wen", {31'd0, rf_write_en}, 32'h1);
        chk("t1_a3", {29'd0, rf_A3}, 32'h5);
        chk("t1_wd3", {16'd0, rf_WD3}, 32'h1234);
        step();
        chk("t1_pend_clr", {24'd0, pending}, 32'h0);
        chk("t1_hazard_clr", {31'd0, hazard}, 32'h0);
        chk("t1_count", {16'd0, wb_count}, 32'h1);
        q_rs1 = 3'd0;

        // Back-to-back contention: four consecutive writes
        for (int r = 1; r <= 4; r++) issue(r[2:0]);
        alu_q.push_back('{3'd1, 16'hA001}); alu_q.push_back('{3'd2, 16'hA002});
        ld_q.push_back('{3'd3, 16'hB003});  ld_q.push_back('{3'd4, 16'hB004});
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t2_wen", {31'd0, rf_write_en}, 32'h1);
        end
        step();
        chk("t2_count", {16'd0, wb_count}, 32'h5);
        chk("t2_pending", {24'd0, pending}, 32'h0);

        // R0 writeback is accepted but never written
        ld_q.push_back('{3'd0, 16'hBEEF});
        step();
        chk("t3_wen", {31'd0, rf_write_en}, 32'h0);
        step();
        chk("t3_count", {16'd0, wb_count}, 32'h5);
        chk("t3_err", {31'd0, err_unexpected}, 32'h0);

        // Commit and re-issue of r3 on the same edge
        issue(3'd3);
        alu_q.push_back('{3'd3, 16'h3333});
        step();
        q_rs2 = 3'd3;
        issue(3'd3);
        chk("t4_pend3", {31'd0, pending[3]}, 32'h1);
        chk("t4_hazard", {31'd0, hazard}, 32'h1);
        alu_q.push_back('{3'd3, 16'h3334});
        step();
        step();
        chk("t4_pend_clr", {24'd0, pending}, 32'h0);
        q_rs2 = 3'd0;

        // Unexpected write is flagged and sticks
        alu_q.push_back('{3'd6, 16'h6666});
        step();
        step();
        chk("t5_err", {31'd0, err_unexpected}, 32'h1);
        issue(3'd2);
        alu_q.push_back('{3'd2, 16'h2222});
        step(); step();
        chk("t5_err_sticky", {31'd0, err_unexpected}, 32'h1);

        // Asynchronous reset while a write is in flight
        for (int r = 1; r <= 7; r++) issue(r[2:0]);
        alu_q.push_back('{3'd1, 16'h1111});
        step();
        alu_valid = 1'b0; ld_valid = 1'b0;
        chk("t6_pre_pend", {24'd0, pending}, 32'hFE);
        chk("t6_pre_wen", {31'd0, rf_write_en}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_pend", {24'd0, pending}, 32'h0);
        chk("t6_rst_wen", {31'd0, rf_write_en}, 32'h0);
        chk("t6_rst_a3", {29'd0, rf_A3}, 32'h0);
        chk("t6_rst_wd3", {16'd0, rf_WD3}, 32'h0);
        chk("t6_rst_count", {16'd0, wb_count}, 32'h0);
        chk("t6_rst_err", {31'd0, err_unexpected}, 32'h0);
        chk("t6_rst_haz", {31'd0, hazard}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_reset();
        issue(3'd1);
        issue(3'd2);
        alu_q.push_back('{3'd1, 16'hC001});
        ld_q.push_back('{3'd2, 16'hD002});
        step();
        chk("t6_tie_a3", {29'd0, rf_A3}, 32'h1);
        chk("t6_tie_wd3", {16'd0, rf_WD3}, 32'hC001);
        step();
        step();

        // Randomized traffic
        for (int c = 0; c < 600; c++) begin
            iss_valid = ($urandom_range(0, 2) == 0);
            iss_rd = 3'($urandom_range(0, 7));
            q_rs1 = 3'($urandom_range(0, 7));
            q_rs2 = 3'($urandom_range(0, 7));
            if (alu_q.size() == 0 && $urandom_range(0, 1) == 1)
                alu_q.push_back('{3'($urandom_range(0, 7)), 16'($urandom)});
            if (ld_q.size() == 0 && $urandom_range(0, 1) == 1)
                ld_q.push_back('{3'($urandom_range(0, 7)), 16'($urandom)});
            step();
        end
        iss_valid = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
